// File: rtl/ap_pkg.sv
// +----------------------------------------------------------------------+
// | ap_pkg: op-codes and select width shared by the address-pointer bank  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package ap_pkg;
  localparam int AP_SELW = 4;

  localparam logic [2:0] AP_NOP     = 3'd0;
  localparam logic [2:0] AP_LOAD    = 3'd1;
  localparam logic [2:0] AP_POSTINC = 3'd2;
  localparam logic [2:0] AP_PREDEC  = 3'd3;
  localparam logic [2:0] AP_ADD     = 3'd4;
  localparam logic [2:0] AP_READ    = 3'd5;
  localparam logic [2:0] AP_CLR     = 3'd6;
endpackage

`default_nettype wire

// File: rtl/ap_addsub.sv
// +----------------------------------------------------------------------+
// | ap_addsub: unsigned pointer plus signed operand, modulo 2^AW, with    |
// | a flag when the true sum leaves 0..2^AW-1.   Rev 1.0                  |
// +----------------------------------------------------------------------+
`default_nettype none

module ap_addsub #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] p_i,
  input  logic [AW-1:0] opnd_i,
  output logic [AW-1:0] res_o,
  output logic          wrap_o
);
  // Two guard bits: bit AW+1 marks a negative sum, bit AW a sum >= 2^AW.
  logic [AW+1:0] sum;

  assign sum    = {2'b00, p_i} + {{2{opnd_i[AW-1]}}, opnd_i};
  assign res_o  = sum[AW-1:0];
  assign wrap_o = sum[AW+1] | sum[AW];
endmodule

`default_nettype wire

// File: rtl/ap_bank.sv
// +----------------------------------------------------------------------+
// | ap_bank: 16-entry address-pointer bank issuing registered addresses   |
// | for load, post-increment, pre-decrement, offset-add, read and clear.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ap_bank
  import ap_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AP_SELW-1:0] ap_sel,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [AW-1:0]      din,
  input  logic [AP_SELW-1:0] rd_idx,
  output logic [AW-1:0]      rd_ptr,
  output logic [AW-1:0]      addr,
  output logic               addr_valid,
  output logic               wrap,
  output logic               err
);
  localparam int NPTR = 1 << AP_SELW;

  logic [AW-1:0] ptr_q [NPTR];
  logic [AW-1:0] addr_q, addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [AW-1:0] p_cur;
  logic [AW-1:0] opnd;
  logic [AW-1:0] sum;
  logic          sum_wrap;
  logic          ptr_we;
  logic [AW-1:0] ptr_d;

  assign p_cur = ptr_q[ap_sel];

  always_comb begin
    opnd = '0;
    case (op)
      AP_POSTINC: opnd = AW'(1);
      AP_PREDEC:  opnd = '1;
      AP_ADD:     opnd = din;
      default:    opnd = '0;
    endcase
  end

  ap_addsub #(.AW(AW)) u_addsub (
    .p_i    (p_cur),
    .opnd_i (opnd),
    .res_o  (sum),
    .wrap_o (sum_wrap)
  );

  always_comb begin
    ptr_we       = 1'b0;
    ptr_d        = sum;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    if (op_valid) begin
      case (op)
        AP_NOP: ;
        AP_LOAD: begin
          ptr_we = 1'b1;
          ptr_d  = din;
        end
        AP_POSTINC: begin
          ptr_we       = 1'b1;
          addr_d       = p_cur;
          addr_valid_d = 1'b1;
          wrap_d       = sum_wrap;
        end
        AP_PREDEC, AP_ADD: begin
          ptr_we       = 1'b1;
          addr_d       = sum;
          addr_valid_d = 1'b1;
          wrap_d       = sum_wrap;
        end
        AP_READ: begin
          addr_d       = p_cur;
          addr_valid_d = 1'b1;
        end
        AP_CLR: begin
          ptr_we = 1'b1;
          ptr_d  = '0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Flop array rather than RAM: async clear of every entry plus combinational read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPTR; i++) ptr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPTR; i++) begin
        if (ptr_we && (ap_sel == AP_SELW'(i))) ptr_q[i] <= ptr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
    end
  end

  assign rd_ptr     = ptr_q[rd_idx];
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
endmodule

`default_nettype wire

// File: tb/tb_ap_bank.sv
// +----------------------------------------------------------------------+
// | tb_ap_bank: directed self-checking bench for ap_bank (AW=16).         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ap_bank;
  import ap_pkg::*;

  localparam int AW = 16;

  logic          clk;
  logic          rst;
  logic [3:0]    ap_sel;
  logic          op_valid;
  logic [2:0]    op;
  logic [AW-1:0] din;
  logic [3:0]    rd_idx;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          wrap;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  ap_bank #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ap_sel     (ap_sel),
    .op_valid   (op_valid),
    .op         (op),
    .din        (din),
    .rd_idx     (rd_idx),
    .rd_ptr     (rd_ptr),
    .addr       (addr),
    .addr_valid (addr_valid),
    .wrap       (wrap),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one operation at the falling edge; return 1 ns after the rising edge.
  task automatic do_op(input logic [3:0] sel, input logic [2:0] o, input logic [AW-1:0] d);
    @(negedge clk);
    ap_sel   = sel;
    op       = o;
    din      = d;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    op_valid = 1'b0;
    op       = AP_NOP;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] idx, input logic [AW-1:0] exp);
    rd_idx = idx;
    #1;
    check(tag, 32'(rd_ptr), 32'(exp));
  endtask

  task automatic pulses(input string tag, input logic av, input logic wr, input logic er);
    check({tag, ".av"},   32'(addr_valid), 32'(av));
    check({tag, ".wrap"}, 32'(wrap),       32'(wr));
    check({tag, ".err"},  32'(err),        32'(er));
  endtask

  initial begin
    rst      = 1'b1;
    ap_sel   = '0;
    op_valid = 1'b0;
    op       = AP_NOP;
    din      = '0;
    rd_idx   = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < 16; i++) rd_check($sformatf("rst.ptr%0d", i), 4'(i), 16'h0000);
    check("rst.addr", 32'(addr), 32'h0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // LOAD then POSTINC x3 on pointer 3
    do_op(4'd3, AP_LOAD, 16'h1000);
    pulses("load", 1'b0, 1'b0, 1'b0);
    do_op(4'd3, AP_POSTINC, 16'h0);
    check("pi1.addr", 32'(addr), 32'h1000);
    pulses("pi1", 1'b1, 1'b0, 1'b0);
    do_op(4'd3, AP_POSTINC, 16'h0);
    check("pi2.addr", 32'(addr), 32'h1001);
    do_op(4'd3, AP_POSTINC, 16'h0);
    check("pi3.addr", 32'(addr), 32'h1002);
    pulses("pi3", 1'b1, 1'b0, 1'b0);
    idle();
    pulses("pi.idle", 1'b0, 1'b0, 1'b0);
    check("pi.hold", 32'(addr), 32'h1002);
    for (int i = 0; i < 16; i++)
      rd_check($sformatf("pi.ptr%0d", i), 4'(i), (i == 3) ? 16'h1003 : 16'h0000);

    // rd_ptr shows the old value in the write cycle, the new one afterwards
    rd_idx = 4'd3;
    @(negedge clk);
    ap_sel = 4'd3; op = AP_POSTINC; op_valid = 1'b1;
    #1 check("rd.pre", 32'(rd_ptr), 32'h1003);
    @(posedge clk);
    #1 check("rd.post", 32'(rd_ptr), 32'h1004);
    check("rd.addr", 32'(addr), 32'h1003);

    // Wrap at the top and bottom of the range
    do_op(4'd5, AP_LOAD, 16'hFFFF);
    do_op(4'd5, AP_POSTINC, 16'h0);
    check("wpi.addr", 32'(addr), 32'hFFFF);
    pulses("wpi", 1'b1, 1'b1, 1'b0);
    rd_check("wpi.ptr", 4'd5, 16'h0000);
    do_op(4'd5, AP_PREDEC, 16'h0);
    check("wpd.addr", 32'(addr), 32'hFFFF);
    pulses("wpd", 1'b1, 1'b1, 1'b0);
    rd_check("wpd.ptr", 4'd5, 16'hFFFF);
    do_op(4'd5, AP_PREDEC, 16'h0);
    check("pd.addr", 32'(addr), 32'hFFFE);
    pulses("pd", 1'b1, 1'b0, 1'b0);

    // Signed ADD
    do_op(4'd7, AP_LOAD, 16'h0008);
    do_op(4'd7, AP_ADD, 16'hFFF0);
    check("addn.addr", 32'(addr), 32'hFFF8);
    pulses("addn", 1'b1, 1'b1, 1'b0);
    do_op(4'd8, AP_LOAD, 16'h0100);
    do_op(4'd8, AP_ADD, 16'h0010);
    check("addp.addr", 32'(addr), 32'h0110);
    pulses("addp", 1'b1, 1'b0, 1'b0);
    do_op(4'd9, AP_LOAD, 16'hFFF0);
    do_op(4'd9, AP_ADD, 16'h0020);
    check("addo.addr", 32'(addr), 32'h0010);
    pulses("addo", 1'b1, 1'b1, 1'b0);
    do_op(4'd10, AP_LOAD, 16'h0001);
    do_op(4'd10, AP_ADD, 16'hFFFF);
    check("addz.addr", 32'(addr), 32'h0000);
    pulses("addz", 1'b1, 1'b0, 1'b0);

    // READ, CLR, NOP
    do_op(4'd8, AP_READ, 16'h0);
    check("read.addr", 32'(addr), 32'h0110);
    pulses("read", 1'b1, 1'b0, 1'b0);
    rd_check("read.ptr", 4'd8, 16'h0110);
    do_op(4'd8, AP_CLR, 16'h0);
    pulses("clr", 1'b0, 1'b0, 1'b0);
    rd_check("clr.ptr", 4'd8, 16'h0000);
    check("clr.addr", 32'(addr), 32'h0110);
    do_op(4'd7, AP_NOP, 16'h0);
    pulses("nop", 1'b0, 1'b0, 1'b0);
    rd_check("nop.ptr", 4'd7, 16'hFFF8);

    // Reserved opcode
    do_op(4'd7, 3'd7, 16'h1234);
    pulses("ill", 1'b0, 1'b0, 1'b1);
    check("ill.addr", 32'(addr), 32'h0110);
    rd_check("ill.ptr", 4'd7, 16'hFFF8);
    idle();
    pulses("ill.idle", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op = 3'd7; op_valid = 1'b0;
    @(posedge clk);
    #1 pulses("ill.nv", 1'b0, 1'b0, 1'b0);

    // Async reset mid-operation with every pointer loaded
    for (int i = 0; i < 16; i++) do_op(4'(i), AP_LOAD, 16'h0100 + 16'(i));
    do_op(4'd15, AP_READ, 16'h0);
    check("pre.addr", 32'(addr), 32'h010F);
    @(negedge clk);
    ap_sel = 4'd2; op = AP_POSTINC; op_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("ar.addr", 32'(addr), 32'h0);
    pulses("ar", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) rd_check($sformatf("ar.ptr%0d", i), 4'(i), 16'h0000);
    @(posedge clk);
    #1 pulses("ar.edge", 1'b0, 1'b0, 1'b0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(4'd2, AP_POSTINC, 16'h0);
    check("res.addr", 32'(addr), 32'h0000);
    pulses("res", 1'b1, 1'b0, 1'b0);
    rd_check("res.ptr", 4'd2, 16'h0001);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ap_bank.md
# ap_bank

Address-pointer register bank that sits directly downstream of the address-pointer select stage. It consumes the 4-bit pointer select, which is registered and already decoded (0..15), and holds 16 address pointers. On each valid operation it updates the selected pointer and issues a registered memory address to the load/store path. It supports load, post-increment, pre-decrement, offset-add, read and clear, so the CPU can walk data structures without going through the general ALU.

## Interface
- AW, 16, address/pointer width in bits (legal 8..32).
- NPTR, 16, pointer count; fixed by the 4-bit select, not overridable.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ap_sel  in  4  pointer index from the select stage, used as-is in the cycle op_valid is high.
- op_valid  in  1  operation strobe, one operation per cycle.
- op  in  3  operation code (see Operation).
- din  in  AW  load value (LOAD) or two's-complement offset (ADD).
- rd_idx  in  4  debug read index.
- rd_ptr  out  AW  combinational value of pointer[rd_idx].
- addr  out  AW  registered address for memory.
- addr_valid  out  1  one-cycle pulse, addr valid.
- wrap  out  1  one-cycle pulse, the pointer update crossed the 0 / 2^AW-1 boundary.
- err  out  1  one-cycle pulse, illegal opcode.

## Operation
Let P = pointer[ap_sel].

- 0 NOP: no change. addr_valid=0.
- 1 LOAD: P<=din. No address issued.
- 2 POSTINC: addr<=P, P<=P+1, addr_valid=1.
- 3 PREDEC: P<=P-1, addr<=P-1, addr_valid=1.
- 4 ADD: P<=P+din, addr<=P+din, addr_valid=1. din is treated as signed.
- 5 READ: addr<=P, addr_valid=1. P is unchanged.
- 6 CLR: P<=0. No address issued.
- 7 reserved: no state change, err=1.

Arithmetic:
- All pointer arithmetic is modulo 2^AW; the result is truncated to AW bits.
- wrap=1 on POSTINC from 2^AW-1, on PREDEC from 0, and on ADD when the signed sum leaves the range 0..2^AW-1.

Other rules:
- When op_valid=0, the op field is ignored and all pulse outputs are 0.
- addr holds its last value when addr_valid=0.
- Only pointer[ap_sel] is written. All other pointers hold.
- rd_ptr shows the pre-update value in the same cycle a write targets rd_idx, and the new value from the next cycle on.

## Timing
- Reset (rst=0, asynchronous): all pointers=0, addr=0, addr_valid=0, wrap=0, err=0. Release is synchronous to clk.
- Reset asserted mid-operation aborts it: no pulse is produced and the pointer is cleared.
- Latency: operation sampled at edge N; addr, addr_valid, wrap and err are valid after edge N, for exactly one cycle.
- Back-to-back operations on the same pointer every cycle are legal. Each operation sees the result of the previous one, since the register is updated on the same edge.
- A change of ap_sel between consecutive operations needs no bubble.
- No backpressure: the memory path accepts every addr_valid pulse.

## Structure
- Shared package ap_pkg holds:
  - op-code localparams: AP_NOP, AP_LOAD, AP_POSTINC, AP_PREDEC, AP_ADD, AP_READ, AP_CLR.
  - the 4-bit select width AP_SELW.
- One sub-module, ap_addsub. It is combinational and takes P and a signed operand. It returns an AW-bit result and a wrap flag, and is used for the +1, -1 and +din cases.
- The pointer array is a flop array, not inferred RAM, because of the asynchronous reset and the combinational rd_ptr.

## Test plan
- Reset, then read all 16 pointers via rd_idx -> all 0. addr=0, no pulses.
- LOAD ap_sel=3, din=0x1000, then POSTINC ×3 on ap_sel=3 -> addr 0x1000, 0x1001, 0x1002 on consecutive cycles. Pointer 3 ends at 0x1003; all other pointers stay 0.
- Wrap, with AW=16:
  - LOAD 0xFFFF, then POSTINC -> addr=0xFFFF, wrap=1, P=0.
  - Then PREDEC -> addr=0xFFFF, wrap=1.
- ADD with din=0xFFF0 (−16) on P=0x0008 -> addr=0xFFF8, wrap=1. ADD with din=0x0010 on P=0x0100 -> addr=0x0110, wrap=0.
- op=7 with op_valid=1 -> err pulse for 1 cycle, no pointer or addr change. The same op with op_valid=0 -> no err.
- Assert rst low asynchronously mid-sequence with pointers 0..15 loaded -> all pointers and outputs 0 immediately, no pulse. Operations resume correctly after release.
